demux1x2_stream: RTL
====================

Name: demux1x2_stream

Overview:
- Registered 1-to-2 stream demultiplexer, the inverse of the 2-to-1 data select in the component library.
- Steers each input word to output 0 or output 1 according to `sel`.
- Uses valid/ready handshakes on all three streams.
- Each output has a one-entry holding register, so a stalled output never corrupts or blocks traffic bound for the other output beyond the current word.
- Used in generated datapaths where a computed value fans out to one of two consumers.

Parameters:
DATAWIDTH, 64, width of data words on `a`, `d0` and `d1` (legal: 2, 8, 16, 32, 64).

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous, active-high reset
a  input  DATAWIDTH  input data word
a_valid  input  1  `a` and `sel` hold a valid word
a_ready  output  1  block accepts the word this cycle
sel  input  1  destination: 0 selects `d0`, 1 selects `d1`; sampled with `a`
d0  output  DATAWIDTH  output 0 data (registered)
d0_valid  output  1  `d0` holds a valid word
d0_ready  input  1  consumer 0 accepts `d0` this cycle
d1  output  DATAWIDTH  output 1 data (registered)
d1_valid  output  1  `d1` holds a valid word
d1_ready  input  1  consumer 1 accepts `d1` this cycle

Behaviour:
- Clocking: one clock `Clk`. `Rst` is synchronous and active-high, sampled on the rising edge of `Clk`.
- Reset values: `d0`=0, `d1`=0, `d0_valid`=0, `d1_valid`=0. `a_ready` follows from the empty holding registers. Reset asserted mid-transfer discards all held words; no output handshake completes in the reset cycle.
- Per-channel state, two states per channel n (0/1):
  - EMPTY (dn_valid=0) -> FULL on load.
  - FULL (dn_valid=1) -> EMPTY on drain without load.
  - FULL stays FULL on drain with load, or while stalled.
- Transfer definitions:
  - Input accept: a_valid && a_ready.
  - Output drain n: dn_valid && dn_ready.
- a_ready (combinational from `sel`, `dn_valid`, `dn_ready`):
  - sel=0: !d0_valid || d0_ready.
  - sel=1: !d1_valid || d1_ready.
  - a_ready does not depend on a_valid.
- Load: on input accept, the selected dn <= a and dn_valid <= 1 at the next edge. The unselected channel is unaffected.
- Latency: a word accepted in cycle t appears on dn with dn_valid=1 in cycle t+1. Throughput is 1 word/cycle per output when the consumer holds dn_ready=1.
- Stall: while dn_valid=1 and dn_ready=0, dn stays bit-stable and dn_valid stays 1. Input words selecting channel n wait with a_ready=0; words selecting the other channel are still accepted if that channel can take them.
- Simultaneous drain and load on the same channel: the new word replaces the old one and dn_valid remains 1. No bubble, no loss.
- Drain on one channel while loading the other: both take effect in the same cycle.
- Data registers update only on load. dn keeps its last value after a drain, and is not cleared while dn_valid=0.
- `sel` change while a_valid=1 and a_ready=0: legal. Routing uses the `sel` value present in the accept cycle.
- Ordering: words to the same output leave in acceptance order. No ordering is guaranteed between outputs.
- No arithmetic. Data passes bit-exact at DATAWIDTH width.

Optional Feature:
- Macro: DEMUX1X2_STREAM_CNT_EN.
- Defined:
  - Adds output ports cnt0 and cnt1, 16 bits each. cntn counts output drains on channel n.
  - Reset to 0; increments by 1 per drain; wraps from 16'hFFFF to 16'h0000 with no flag.
  - The count is visible the cycle after the drain.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert Rst for 2 cycles with a_valid=1 -> d0_valid=d1_valid=0, d0=d1=0, a_ready=1, and no load in the reset cycles.
- Steering: a=64'h11 sel=0, then a=64'h22 sel=1, with both readys=1 -> d0=64'h11 valid in cycle t+1, d1=64'h22 valid in cycle t+2, each valid for exactly 1 cycle.
- Back-pressure isolation: d0_ready=0, send 64'hA0 then 64'hA1 with sel=0, then 64'hB0 with sel=1 ->
  - d0 holds 64'hA0 stable.
  - a_ready=0 while 64'hA1 is presented.
  - Switching to sel=1 accepts 64'hB0, which appears on d1.
  - Releasing d0_ready drains 64'hA0, then 64'hA1.
- Full throughput: 8 consecutive words 1..8 with sel=0 and d0_ready=1 -> a_ready stays 1, d0 shows 1..8 in consecutive cycles, no bubbles.
- Reset mid-stall: d1 holding 64'h5A with d1_ready=0, assert Rst -> d1_valid=0 next cycle, and 64'h5A is never drained afterwards.
- DEMUX1X2_STREAM_CNT_EN: drain 3 words on d0 and 65537 words on d1 -> cnt0=3, cnt1=1 (wrapped).

Source files
------------

// File: rtl/demux1x2_stream.sv
// rtl/demux1x2_stream.sv - registered 1-to-2 valid/ready stream demultiplexer
//
// Steers each accepted input word to d0 or d1 according to sel. Each output
// owns a one-entry holding register, so a stalled consumer only blocks words
// routed to its own channel.
//
// Optional feature macro: DEMUX1X2_STREAM_CNT_EN (adds 16-bit drain counters).
//
// Ports:
//   Clk, Rst            rising-edge clock, synchronous active-high reset
//   a, sel, a_valid     input word, destination select, input valid
//   a_ready             input accepted this cycle (combinational)
//   d0, d0_valid        output 0 word and valid (registered)
//   d0_ready            consumer 0 ready
//   d1, d1_valid        output 1 word and valid (registered)
//   d1_ready            consumer 1 ready
//   cnt0, cnt1          drain counts per channel (DEMUX1X2_STREAM_CNT_EN only)

module demux1x2_stream #(
   parameter int DATAWIDTH = 64
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] a,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic                 sel,
   output logic [DATAWIDTH-1:0] d0,
   output logic                 d0_valid,
   input  logic                 d0_ready,
   output logic [DATAWIDTH-1:0] d1,
   output logic                 d1_valid,
   input  logic                 d1_ready
`ifdef DEMUX1X2_STREAM_CNT_EN
   ,
   output logic [15:0]          cnt0,
   output logic [15:0]          cnt1
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t               r_state0, r_state1;
   state_t               w_next0, w_next1;
   logic [DATAWIDTH-1:0] r_d0, r_d1;
   logic                 w_accept;
   logic                 w_load0, w_load1;
   logic                 w_drain0, w_drain1;
   logic                 w_a_ready;

   assign w_drain0 = (r_state0 == ST_FULL) && d0_ready;
   assign w_drain1 = (r_state1 == ST_FULL) && d1_ready;

   // A channel can take a word when it is empty or is being drained this
   // cycle; only the selected channel matters.
   assign w_a_ready = sel ? ((r_state1 == ST_EMPTY) || d1_ready)
                          : ((r_state0 == ST_EMPTY) || d0_ready);

   assign w_accept = a_valid && w_a_ready;
   assign w_load0  = w_accept && !sel;
   assign w_load1  = w_accept &&  sel;

   always_comb begin
      w_next0 = r_state0;
      w_next1 = r_state1;
      // Load wins over drain so a simultaneous drain+load keeps the channel full.
      if (w_load0)
         w_next0 = ST_FULL;
      else if (w_drain0)
         w_next0 = ST_EMPTY;
      if (w_load1)
         w_next1 = ST_FULL;
      else if (w_drain1)
         w_next1 = ST_EMPTY;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state0 <= ST_EMPTY;
         r_state1 <= ST_EMPTY;
         r_d0     <= '0;
         r_d1     <= '0;
      end else begin
         r_state0 <= w_next0;
         r_state1 <= w_next1;
         // Data registers change only on load; they keep the last word after a drain.
         if (w_load0)
            r_d0 <= a;
         if (w_load1)
            r_d1 <= a;
      end
   end

   assign a_ready  = w_a_ready;
   assign d0       = r_d0;
   assign d1       = r_d1;
   assign d0_valid = (r_state0 == ST_FULL);
   assign d1_valid = (r_state1 == ST_FULL);

`ifdef DEMUX1X2_STREAM_CNT_EN
   logic [15:0] r_cnt0, r_cnt1;

   // Free-running drain counters; wrap silently at 16 bits.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_drain0)
            r_cnt0 <= r_cnt0 + 16'd1;
         if (w_drain1)
            r_cnt1 <= r_cnt1 + 16'd1;
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`endif

endmodule
